// File: rtl/rtc_timekeeper.sv
// 24-hour time-of-day counter with 1 Hz prescaler and button-driven set-time edit mode.
// Optional AMPM_DISPLAY_EN adds registered 12-hour HOUR12/PM outputs.
module rtc_timekeeper #(
    parameter int unsigned CLK_HZ  = 1000,
    parameter int unsigned PRESC_W = 16
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [2:0] STATE,
    input  logic       up,
    input  logic       down,
    input  logic       shift,
    input  logic       OK,
    output logic [6:0] HOUR,
    output logic [6:0] MIN,
    output logic [6:0] SEC,
    output logic [1:0] FIELD,
`ifdef AMPM_DISPLAY_EN
    output logic [6:0] HOUR12,
    output logic       PM,
`endif
    output logic       SEC_TICK
);

    localparam logic [PRESC_W-1:0] PrescMax  = PRESC_W'(CLK_HZ - 1);
    localparam logic [6:0]         HourMax   = 7'd23;
    localparam logic [6:0]         MinSecMax = 7'd59;

    function automatic logic [6:0] wrap_inc(input logic [6:0] v, input logic [6:0] max);
        return (v == max) ? 7'd0 : v + 7'd1;
    endfunction

    function automatic logic [6:0] wrap_dec(input logic [6:0] v, input logic [6:0] max);
        return (v == 7'd0) ? max : v - 7'd1;
    endfunction

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               sec_tick_q, sec_tick_d;
    logic [6:0]         run_h_q, run_h_d, run_m_q, run_m_d, run_s_q, run_s_d;
    logic [6:0]         edit_h_q, edit_h_d, edit_m_q, edit_m_d, edit_s_q, edit_s_d;
    logic [1:0]         field_q, field_d;
    logic [2:0]         state_prev_q, state_prev_d;
    logic [6:0]         hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic               tick, in_edit, entry, commit;

    always_comb begin
        in_edit = (STATE == 3'd1);
        entry   = in_edit && (state_prev_q != 3'd1);
        // Buttons are ignored on the entry cycle since the edit registers are still loading.
        commit  = in_edit && !entry && OK;
        tick    = (presc_q == PrescMax);

        presc_d      = (tick || commit) ? '0 : presc_q + PRESC_W'(1);
        sec_tick_d   = tick && !commit;
        state_prev_d = STATE;

        run_h_d = run_h_q;
        run_m_d = run_m_q;
        run_s_d = run_s_q;
        if (commit) begin
            run_h_d = edit_h_q;
            run_m_d = edit_m_q;
            run_s_d = edit_s_q;
        end else if (tick) begin
            run_s_d = wrap_inc(run_s_q, MinSecMax);
            if (run_s_q == MinSecMax) begin
                run_m_d = wrap_inc(run_m_q, MinSecMax);
                if (run_m_q == MinSecMax) begin
                    run_h_d = wrap_inc(run_h_q, HourMax);
                end
            end
        end

        edit_h_d = edit_h_q;
        edit_m_d = edit_m_q;
        edit_s_d = edit_s_q;
        field_d  = field_q;
        if (!in_edit) begin
            field_d = 2'd0;
        end else if (entry) begin
            edit_h_d = run_h_q;
            edit_m_d = run_m_q;
            edit_s_d = run_s_q;
            field_d  = 2'd1;
        end else begin
            if (up != down) begin
                case (field_q)
                    2'd1:    edit_h_d = up ? wrap_inc(edit_h_q, HourMax)
                                           : wrap_dec(edit_h_q, HourMax);
                    2'd2:    edit_m_d = up ? wrap_inc(edit_m_q, MinSecMax)
                                           : wrap_dec(edit_m_q, MinSecMax);
                    2'd3:    edit_s_d = up ? wrap_inc(edit_s_q, MinSecMax)
                                           : wrap_dec(edit_s_q, MinSecMax);
                    default: ;
                endcase
            end
            if (shift) begin
                field_d = (field_q == 2'd3) ? 2'd1 : field_q + 2'd1;
            end
        end

        hour_d = in_edit ? edit_h_d : run_h_d;
        min_d  = in_edit ? edit_m_d : run_m_d;
        sec_d  = in_edit ? edit_s_d : run_s_d;
    end

`ifdef AMPM_DISPLAY_EN
    logic [6:0] hour12_q, hour12_d;
    logic       pm_q, pm_d;

    always_comb begin
        if (hour_d == 7'd0) begin
            hour12_d = 7'd12;
            pm_d     = 1'b0;
        end else if (hour_d < 7'd12) begin
            hour12_d = hour_d;
            pm_d     = 1'b0;
        end else if (hour_d == 7'd12) begin
            hour12_d = 7'd12;
            pm_d     = 1'b1;
        end else begin
            hour12_d = hour_d - 7'd12;
            pm_d     = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            hour12_q <= 7'd12;
            pm_q     <= 1'b0;
        end else begin
            hour12_q <= hour12_d;
            pm_q     <= pm_d;
        end
    end

    assign HOUR12 = hour12_q;
    assign PM     = pm_q;
`endif

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            presc_q      <= '0;
            sec_tick_q   <= 1'b0;
            run_h_q      <= 7'd0;
            run_m_q      <= 7'd0;
            run_s_q      <= 7'd0;
            edit_h_q     <= 7'd0;
            edit_m_q     <= 7'd0;
            edit_s_q     <= 7'd0;
            field_q      <= 2'd0;
            state_prev_q <= 3'd0;
            hour_q       <= 7'd0;
            min_q        <= 7'd0;
            sec_q        <= 7'd0;
        end else begin
            presc_q      <= presc_d;
            sec_tick_q   <= sec_tick_d;
            run_h_q      <= run_h_d;
            run_m_q      <= run_m_d;
            run_s_q      <= run_s_d;
            edit_h_q     <= edit_h_d;
            edit_m_q     <= edit_m_d;
            edit_s_q     <= edit_s_d;
            field_q      <= field_d;
            state_prev_q <= state_prev_d;
            hour_q       <= hour_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
        end
    end

    assign HOUR     = hour_q;
    assign MIN      = min_q;
    assign SEC      = sec_q;
    assign FIELD    = field_q;
    assign SEC_TICK = sec_tick_q;

endmodule
